// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one ALU: grants one request at a time,
// computes it in a single cycle and holds the response until the requester accepts it.

package alu_pkg;
  localparam int ALU_ADD = 8'h00;
  localparam int ALU_SUB = 8'h01;
  localparam int ALU_AND = 8'h02;
  localparam int ALU_OR  = 8'h03;
  localparam int ALU_XOR = 8'h04;
  localparam int ALU_SLL = 8'h05;
  localparam int ALU_SRL = 8'h06;
  localparam int ALU_SRA = 8'h07;
  localparam int ALU_SLT = 8'h08;
endpackage

module alu #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 8
) (
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] result,
  output logic              illegal
);
  import alu_pkg::*;

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] shamt;
  assign shamt = op2[SH_W-1:0];

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (op)
      OP_W'(ALU_ADD): result = op1 + op2;
      OP_W'(ALU_SUB): result = op1 - op2;
      OP_W'(ALU_AND): result = op1 & op2;
      OP_W'(ALU_OR):  result = op1 | op2;
      OP_W'(ALU_XOR): result = op1 ^ op2;
      OP_W'(ALU_SLL): result = op1 << shamt;
      OP_W'(ALU_SRL): result = op1 >> shamt;
      OP_W'(ALU_SRA): result = DATA_W'($signed(op1) >>> shamt);
      OP_W'(ALU_SLT): result = {{(DATA_W-1){1'b0}}, (op1 < op2)};
      default:        illegal = 1'b1;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [1:0]        i_req_valid,
  output logic [1:0]        o_req_ready,
  input  logic [DATA_W-1:0] i_req0_op1,
  input  logic [DATA_W-1:0] i_req0_op2,
  input  logic [DATA_W-1:0] i_req1_op1,
  input  logic [DATA_W-1:0] i_req1_op2,
  input  logic [OP_W-1:0]   i_req0_op,
  input  logic [OP_W-1:0]   i_req1_op,
  output logic [1:0]        o_rsp_valid,
  input  logic [1:0]        i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rsp_err,
  output logic              o_busy,
  output logic [1:0]        o_dbg_state
);
  // Handshake: a beat moves on a rising edge where valid[k] & ready[k]; valid never
  // waits on ready, and a response holds data/err stable until its own ready bit is seen.
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t            state;
  logic              prio;
  logic              id;
  logic [DATA_W-1:0] op1_q;
  logic [DATA_W-1:0] op2_q;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] alu_result;
  logic              alu_illegal;
  logic [1:0]        grant;

  alu #(.DATA_W(DATA_W), .OP_W(OP_W)) u_alu (
    .op1     (op1_q),
    .op2     (op2_q),
    .op      (op_q),
    .result  (alu_result),
    .illegal (alu_illegal)
  );

  // Contention is settled by the pointer, which always names the requester that lost last.
  always_comb begin
    grant = 2'b00;
    if (state == IDLE) begin
      case (i_req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = prio ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign o_req_ready = grant;
  assign o_busy      = (state != IDLE);
  assign o_dbg_state = state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      prio        <= 1'b0;
      id          <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      op_q        <= '0;
      o_rsp_valid <= 2'b00;
      o_rsp_data  <= '0;
      o_rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            id    <= grant[1];
            op1_q <= grant[1] ? i_req1_op1 : i_req0_op1;
            op2_q <= grant[1] ? i_req1_op2 : i_req0_op2;
            op_q  <= grant[1] ? i_req1_op  : i_req0_op;
            prio  <= ~grant[1];
            state <= EXEC;
          end
        end
        EXEC: begin
          o_rsp_data  <= alu_result;
          o_rsp_err   <= alu_illegal;
          o_rsp_valid <= id ? 2'b10 : 2'b01;
          state       <= RESP;
        end
        RESP: begin
          if (i_rsp_ready[id]) begin
            o_rsp_valid <= 2'b00;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model of grant order, latency and ALU results.

module tb_alu_arbiter;
  localparam logic [7:0] OP_ADD = 8'h00;
  localparam logic [7:0] OP_SUB = 8'h01;
  localparam logic [7:0] OP_AND = 8'h02;
  localparam logic [7:0] OP_OR  = 8'h03;
  localparam logic [7:0] OP_XOR = 8'h04;
  localparam logic [7:0] OP_SLL = 8'h05;
  localparam logic [7:0] OP_SRL = 8'h06;
  localparam logic [7:0] OP_SRA = 8'h07;
  localparam logic [7:0] OP_SLT = 8'h08;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [31:0] req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
  logic [7:0]  req0_op = '0, req1_op = '0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b00;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic [1:0]  dbg_state;

  alu_arbiter #(.DATA_W(32), .OP_W(8)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req0_op1  (req0_op1),
    .i_req0_op2  (req0_op2),
    .i_req1_op1  (req1_op1),
    .i_req1_op2  (req1_op2),
    .i_req0_op   (req0_op),
    .i_req1_op   (req1_op),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_data  (rsp_data),
    .o_rsp_err   (rsp_err),
    .o_busy      (busy),
    .o_dbg_state (dbg_state)
  );

  // scoreboard: {id, err, data} of the transaction in flight
  logic [33:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int age = -1;         // cycles since the model's last transfer, -1 when nothing in flight
  logic exp_prio = 1'b0;
  int dut_xfers = 0;
  int dut_rsps = 0;
  logic grant_log[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [7:0] op);
    int unsigned sh;
    sh = b[4:0];
    case (op)
      OP_ADD:  return {1'b0, a + b};
      OP_SUB:  return {1'b0, a - b};
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      OP_XOR:  return {1'b0, a ^ b};
      OP_SLL:  return {1'b0, a << sh};
      OP_SRL:  return {1'b0, a >> sh};
      OP_SRA:  return {1'b0, a[31] ? ~((~a) >> sh) : (a >> sh)};
      OP_SLT:  return {1'b0, (a < b) ? 32'd1 : 32'd0};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  function automatic logic [7:0] rand_op();
    int r;
    r = $urandom_range(0, 11);
    if (r <= 8) return 8'(r);
    return 8'($urandom_range(9, 255));
  endfunction

  task automatic model_reset();
    exp_q.delete();
    age = -1;
    exp_prio = 1'b0;
  endtask

  // Driver + per-cycle check; called at a falling edge, returns at the next one.
  task automatic cycle(input logic [1:0] v, input logic [1:0] rr);
    logic [1:0]  exp_ready;
    logic [33:0] head;
    logic [32:0] res;
    req_valid = v;
    rsp_ready = rr;
    #1;
    exp_ready = 2'b00;
    if (age < 0) begin
      if (v == 2'b01) exp_ready = 2'b01;
      else if (v == 2'b10) exp_ready = 2'b10;
      else if (v == 2'b11) exp_ready = exp_prio ? 2'b10 : 2'b01;
    end
    check("req_ready", req_ready, exp_ready);
    check("busy", busy, (age >= 0));
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    if (age >= 1) begin
      check("rsp_valid", rsp_valid, head[33] ? 2'b10 : 2'b01);
      check("rsp_data", rsp_data, head[31:0]);
      check("rsp_err", rsp_err, head[32]);
    end else begin
      check("rsp_valid_idle", rsp_valid, 2'b00);
    end
    if ((req_ready & v) != 2'b00) begin
      dut_xfers++;
      grant_log.push_back(req_ready[1]);
    end
    if ((rsp_valid & rr) != 2'b00) dut_rsps++;
    @(posedge clk);
    if (age < 0) begin
      if (exp_ready != 2'b00) begin
        if (exp_ready[1]) res = ref_alu(req1_op1, req1_op2, req1_op);
        else              res = ref_alu(req0_op1, req0_op2, req0_op);
        exp_q.push_back({exp_ready[1], res});
        exp_prio = ~exp_ready[1];
        age = 0;
      end
    end else if (age == 0) begin
      age = 1;
    end else if (rr[head[33]]) begin
      void'(exp_q.pop_front());
      age = -1;
    end
    @(negedge clk);
  endtask

  // One isolated transaction with explicit result checks and an optional hold phase.
  task automatic run_single(input logic id, input logic [31:0] a, input logic [31:0] b,
                            input logic [7:0] op, input logic [31:0] exp_data,
                            input logic exp_err, input int hold, input string tag);
    logic [1:0] tgt;
    tgt = id ? 2'b10 : 2'b01;
    if (id) begin req1_op1 = a; req1_op2 = b; req1_op = op; end
    else    begin req0_op1 = a; req0_op2 = b; req0_op = op; end
    cycle(tgt, 2'b00);
    cycle(2'b00, 2'b00);
    check({tag, "_valid"}, rsp_valid, tgt);
    check({tag, "_data"}, rsp_data, exp_data);
    check({tag, "_err"}, rsp_err, exp_err);
    for (int i = 0; i < hold; i++) cycle(2'b00, 2'b00);
    if (hold > 0) cycle(2'b00, ~tgt);
    check({tag, "_held"}, rsp_valid, tgt);
    cycle(2'b00, tgt);
    check({tag, "_done"}, rsp_valid, 2'b00);
  endtask

  initial begin
    int x0;
    int r0;
    // reset state
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready_idle", req_ready, 2'b00);
    req_valid = 2'b11;
    #1;
    check("rst_ready_valid", req_ready, 2'b01);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // contention right after reset: strict alternation starting at requester 0
    req0_op1 = 32'd10; req0_op2 = 32'd3; req0_op = OP_SUB;
    req1_op1 = 32'hF0; req1_op2 = 32'hFF; req1_op = OP_XOR;
    grant_log.delete();
    for (int i = 0; i < 12; i++) cycle(2'b11, 2'b11);
    check("alt_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check($sformatf("alt_grant%0d", i), grant_log[i], i % 2);

    run_single(1'b0, 32'd5, 32'd7, OP_ADD, 32'd12, 1'b0, 0, "add");
    run_single(1'b1, 32'h8000_0000, 32'h24, OP_SRA, 32'hF800_0000, 1'b0, 0, "sra");
    run_single(1'b1, 32'd1, 32'd31, OP_SLL, 32'h8000_0000, 1'b0, 0, "sll");
    run_single(1'b0, 32'd0, 32'd3, OP_SLT, 32'd1, 1'b0, 0, "slt");
    run_single(1'b0, 32'h1234, 32'h5678, 8'hFF, 32'd0, 1'b1, 5, "bad_op");

    // reset while a response is pending
    req1_op1 = 32'h11; req1_op2 = 32'h22; req1_op = OP_XOR;
    cycle(2'b10, 2'b00);
    cycle(2'b00, 2'b00);
    check("abort_pre_valid", rsp_valid, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    check("abort_valid", rsp_valid, 2'b00);
    check("abort_busy", busy, 1'b0);
    check("abort_state", dbg_state, 2'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle(2'b00, 2'b11);

    // back-to-back with responses always accepted: one transfer every 3 cycles
    x0 = dut_xfers;
    r0 = dut_rsps;
    for (int i = 0; i < 30; i++) begin
      req0_op1 = $urandom; req0_op2 = $urandom; req0_op = rand_op();
      req1_op1 = $urandom; req1_op2 = $urandom; req1_op = rand_op();
      cycle(2'b11, 2'b11);
    end
    check("b2b_xfers", dut_xfers - x0, 10);
    check("b2b_rsps", dut_rsps - r0, 10);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      req0_op1 = $urandom; req0_op2 = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 63)) : $urandom;
      req0_op = rand_op();
      req1_op1 = $urandom; req1_op2 = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 63)) : $urandom;
      req1_op = rand_op();
      cycle(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 4; i++) cycle(2'b00, 2'b11);
    check("drain_empty", exp_q.size(), 0);
    check("drain_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
